vga_mode_ctrl: RTL and testbench

- Selects which test pattern the VGA pattern generator displays by driving its 2-bit mux select.
- Takes a raw pushbutton for manual stepping and an optional auto-cycle mode that steps after a fixed number of frames.
- Pattern changes take effect only at the start of vertical blank, so no frame ever shows a mid-frame pattern change.
- Sits between the board button/switch inputs, the VGA timing counter (vcount) and the pattern generator.

---
 rtl/vga_mode_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: selects the VGA test pattern (mux) from a debounced
// pushbutton and an optional auto-cycle mode. Pattern changes are applied
// only at the start of vertical blank, so a frame never shows two patterns.
//
// Output contract: mux is a plain registered level. mode_changed is a
// one-cycle strobe that acts as the "valid" qualifier for mux; it is high
// on exactly the cycle where mux first shows a new value. There is no ready
// (the pattern generator always accepts). mux changes on no other cycle,
// except when reset forces it to 0, and that reset does not raise mode_changed.
module vga_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAMES_PER_MODE = 120,
  parameter int V_ACTIVE        = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic [10:0] vcount,
  output logic [1:0]  mux,
  output logic        frame_tick,
  output logic        mode_changed,
  output logic [1:0]  dbg_state
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]        FRAME_LAST = 8'(FRAMES_PER_MODE - 1);
  localparam logic [10:0]       V_BLANK    = 11'(V_ACTIVE);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Synchronizer and debounce state
  logic             btn_meta;
  logic             btn_s;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_evt;

  // Frame / mode state
  logic [10:0]      vcount_d;
  logic             boundary;
  logic             pending;
  logic [7:0]       frame_cnt;
  logic             auto_hit;
  logic             advance;

  assign dbg_state = state;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_next;
      btn_s    <= btn_meta;
    end
  end

  // Debounce FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Debounce next-state: a level must persist DEBOUNCE_CYCLES samples to be accepted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Debounce output: one press event on the cycle the press is accepted.
  always_comb begin
    press_evt = 1'b0;
    if (state == PRESS_WAIT && btn_s && cnt == CNT_LAST) begin
      press_evt = 1'b1;
    end
  end

  // Frame boundary: first cycle vcount reaches the start of vertical blank.
  assign boundary = (vcount == V_BLANK) && (vcount_d != V_BLANK);
  assign auto_hit = auto_en && (frame_cnt == FRAME_LAST);
  assign advance  = boundary && (pending || auto_hit);

  // Delayed vcount copy for edge detection of the blank start.
  always_ff @(posedge clk) begin
    if (reset) begin
      vcount_d <= '0;
    end else begin
      vcount_d <= vcount;
    end
  end

  // Pending press: collapses multiple presses per frame; a press on the boundary waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (boundary) begin
      pending <= press_evt;
    end else if (press_evt) begin
      pending <= 1'b1;
    end
  end

  // Mode register, strobes and auto frame counter, all updated at the boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux          <= 2'd0;
      frame_tick   <= 1'b0;
      mode_changed <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      frame_tick   <= boundary;
      mode_changed <= advance;
      if (advance) begin
        mux       <= (mux == 2'd2) ? 2'd0 : mux + 2'd1;
        frame_cnt <= 8'd0;
      end else if (boundary) begin
        frame_cnt <= auto_en ? frame_cnt + 8'd1 : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// tb_vga_mode_ctrl: directed bench for vga_mode_ctrl with a scoreboard queue
// of expected mux values, popped by a monitor on every mode_changed strobe.
module tb_vga_mode_ctrl;

  localparam int DEB    = 4;
  localparam int FRAMES = 3;
  localparam int VACT   = 480;

  logic        clk;
  logic        reset;
  logic        btn_next;
  logic        auto_en;
  logic [10:0] vcount;
  logic [1:0]  mux;
  logic        frame_tick;
  logic        mode_changed;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int mc_seen = 0;
  int exp_ticks = 0;
  int exp_mc = 0;
  logic [1:0] mux_prev = 2'd0;
  logic [1:0] exp_q[$];

  vga_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .FRAMES_PER_MODE (FRAMES),
    .V_ACTIVE        (VACT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_next     (btn_next),
    .auto_en      (auto_en),
    .vcount       (vcount),
    .mux          (mux),
    .frame_tick   (frame_tick),
    .mode_changed (mode_changed),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    vcount   = 11'd0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  // One button press held for 'hold' cycles, followed by a settling gap.
  task automatic press(input int hold);
    btn_next = 1'b1;
    repeat (hold) step();
    btn_next = 1'b0;
    repeat (10) step();
  endtask

  // One frame: vcount 479 -> 480 (held a few cycles) -> back into active.
  task automatic frame();
    vcount = 11'(VACT - 1);
    repeat (2) step();
    vcount = 11'(VACT);
    repeat (3) step();
    vcount = 11'd5;
    step();
    exp_ticks++;
  endtask

  task automatic expect_step(input logic [1:0] m);
    exp_q.push_back(m);
    exp_mc++;
  endtask

  task automatic check_state(input string name, input logic [1:0] m);
    check({name, "_mux"}, 32'(mux), 32'(m));
    check({name, "_ticks"}, 32'(tick_seen), 32'(exp_ticks));
    check({name, "_mc"}, 32'(mc_seen), 32'(exp_mc));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mode_changed) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mode_change: got mux %0d expected no change", mux);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (mux !== e) begin
          errors++;
          $display("FAIL mux_on_change: got %0d expected %0d", mux, e);
        end
      end
      checks++;
      if (frame_tick !== 1'b1) begin
        errors++;
        $display("FAIL change_with_tick: got frame_tick %0d expected 1", frame_tick);
      end
    end
    if (!reset) begin
      checks++;
      if ((mux !== mux_prev && !mode_changed) || mux === 2'd3) begin
        errors++;
        $display("FAIL mux_stable: got %0d expected %0d", mux, mux_prev);
      end
    end
    mux_prev = mux;
    if (frame_tick === 1'b1) tick_seen++;
    if (mode_changed === 1'b1) mc_seen++;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    btn_next = 1'b1;
    auto_en  = 1'b0;
    vcount   = 11'd478;

    // Reset held 3 cycles while button pressed and vcount crosses 480.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mux", 32'(mux), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_mc", 32'(mode_changed), 32'd0);
      check("rst_fsm", 32'(dbg_state), 32'd0);
      vcount = vcount + 11'd1;
    end
    vcount = 11'(VACT - 1);
    reset  = 1'b0;
    step();
    // Boundary right after release: no press accepted yet.
    vcount = 11'(VACT);
    step();
    btn_next = 1'b0;
    step();
    exp_ticks++;
    vcount = 11'd5;
    repeat (10) step();
    check_state("post_reset", 2'd0);
    frame();
    check_state("post_reset_frame", 2'd0);
    check("post_reset_fsm", 32'(dbg_state), 32'd0);

    // 3-cycle glitch is rejected.
    do_reset();
    press(3);
    frame();
    check_state("glitch", 2'd0);

    // 10-cycle press accepted and applied at the next boundary.
    press(10);
    check("before_boundary_mux", 32'(mux), 32'd0);
    expect_step(2'd1);
    frame();
    check_state("valid_press", 2'd1);

    // Three presses in one frame collapse to one step.
    do_reset();
    press(10);
    press(10);
    press(10);
    expect_step(2'd1);
    frame();
    check_state("collapse", 2'd1);

    // Six presses across six frames wrap through 1,2,0,1,2,0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(10);
      expect_step(2'((i + 1) % 3));
      frame();
    end
    check_state("wrap", 2'd0);

    // Auto mode: a step every third frame.
    do_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 0) expect_step(2'((i / 3) % 3));
      frame();
    end
    check_state("auto", 2'd0);

    // Auto disabled across a boundary restarts the count.
    do_reset();
    auto_en = 1'b1;
    frame();
    frame();
    auto_en = 1'b0;
    frame();
    auto_en = 1'b1;
    frame();
    frame();
    check_state("auto_restart_wait", 2'd0);
    expect_step(2'd1);
    frame();
    check_state("auto_restart", 2'd1);

    // Manual pending plus auto hit in the same boundary: single step.
    do_reset();
    auto_en = 1'b1;
    frame();
    frame();
    press(10);
    expect_step(2'd1);
    frame();
    check_state("simul", 2'd1);
    frame();
    frame();
    check_state("simul_cnt_cleared", 2'd1);
    expect_step(2'd2);
    frame();
    check_state("simul_next_auto", 2'd2);

    // Press event landing on the boundary cycle waits for the next boundary.
    do_reset();
    vcount = 11'(VACT - 1);
    repeat (3) step();
    btn_next = 1'b1;
    repeat (5) step();
    vcount = 11'(VACT);
    exp_ticks++;
    repeat (5) step();
    btn_next = 1'b0;
    repeat (10) step();
    check_state("coincident_held", 2'd0);
    expect_step(2'd1);
    frame();
    check_state("coincident_applied", 2'd1);

    // vcount stuck at 480: one tick, pending applied once.
    do_reset();
    press(10);
    expect_step(2'd1);
    vcount = 11'(VACT - 1);
    repeat (2) step();
    vcount = 11'(VACT);
    repeat (1000) step();
    vcount = 11'd5;
    step();
    exp_ticks++;
    check_state("held_vcount", 2'd1);

    // ---------------- final report ----------------
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
